// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter for the shared data RAM
module dmem_arbiter #(
   parameter int            AW        = 8,
   parameter int            DW        = 64,
   parameter int            MAX_BURST = 4,
   parameter logic [AW-1:0] IO_ADDR   = '1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_a_req,
   input  logic          i_a_we,
   input  logic [AW-1:0] i_a_addr,
   input  logic [DW-1:0] i_a_wdata,
   output logic          o_a_gnt,
   output logic          o_a_rvalid,
   output logic [DW-1:0] o_a_rdata,
   input  logic          i_b_req,
   input  logic          i_b_we,
   input  logic [AW-1:0] i_b_addr,
   input  logic [DW-1:0] i_b_wdata,
   output logic          o_b_gnt,
   output logic          o_b_rvalid,
   output logic [DW-1:0] o_b_rdata,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_io_write,
   output logic [DW-1:0] o_io_data
);

   localparam int            BW   = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

   typedef enum logic [1:0] {ST_IDLE, ST_OWN_A, ST_OWN_B} state_t;

   state_t        r_state;
   logic [BW-1:0] r_beats;
   logic          r_last_b;
   logic          r_rd_pend;
   logic          r_rd_port_b;
   logic          r_io_write;
   logic [DW-1:0] r_io_data;

   logic w_own_a;
   logic w_own_b;
   logic w_burst_ok;
   logic w_pick_a;
   logic w_pick_b;
   logic w_gnt_a;
   logic w_gnt_b;
   logic w_io_hit;

   assign w_own_a    = (r_state == ST_OWN_A);
   assign w_own_b    = (r_state == ST_OWN_B);
   assign w_burst_ok = (r_beats < MAXB);

   // Grant choice: owner keeps the RAM until its burst budget runs out or it lets go
   always_comb begin
      w_pick_a = 1'b0;
      w_pick_b = 1'b0;
      if (w_own_a && i_a_req && (!i_b_req || w_burst_ok)) begin
         w_pick_a = 1'b1;
      end else if (w_own_b && i_b_req && (!i_a_req || w_burst_ok)) begin
         w_pick_b = 1'b1;
      end else if (i_a_req && i_b_req) begin
         if (w_own_a)       w_pick_b = 1'b1;
         else if (w_own_b)  w_pick_a = 1'b1;
         else if (r_last_b) w_pick_a = 1'b1;
         else               w_pick_b = 1'b1;
      end else if (i_a_req) begin
         w_pick_a = 1'b1;
      end else if (i_b_req) begin
         w_pick_b = 1'b1;
      end
   end

   // Reset is asynchronous, so grants are forced low while it is held
   assign w_gnt_a = w_pick_a & i_rst_n;
   assign w_gnt_b = w_pick_b & i_rst_n;
   assign o_a_gnt = w_gnt_a;
   assign o_b_gnt = w_gnt_b;

   assign o_mem_en    = w_gnt_a | w_gnt_b;
   assign o_mem_we    = w_gnt_a ? i_a_we    : (w_gnt_b ? i_b_we    : 1'b0);
   assign o_mem_addr  = w_gnt_a ? i_a_addr  : (w_gnt_b ? i_b_addr  : '0);
   assign o_mem_wdata = w_gnt_a ? i_a_wdata : (w_gnt_b ? i_b_wdata : '0);

   assign w_io_hit = o_mem_en & o_mem_we & (o_mem_addr == IO_ADDR);

   // Ownership FSM: tracks current owner, its consecutive grant count and last winner
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_beats  <= '0;
         r_last_b <= 1'b1;
      end else if (w_gnt_a) begin
         r_state  <= ST_OWN_A;
         r_beats  <= w_own_a ? (w_burst_ok ? r_beats + BW'(1) : MAXB) : BW'(1);
         r_last_b <= 1'b0;
      end else if (w_gnt_b) begin
         r_state  <= ST_OWN_B;
         r_beats  <= w_own_b ? (w_burst_ok ? r_beats + BW'(1) : MAXB) : BW'(1);
         r_last_b <= 1'b1;
      end else begin
         r_state  <= ST_IDLE;
         r_beats  <= '0;
      end
   end

   // Read-return steering and IO strobe, both one cycle after the accepted access
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_pend   <= 1'b0;
         r_rd_port_b <= 1'b0;
         r_io_write  <= 1'b0;
         r_io_data   <= '0;
      end else begin
         r_rd_pend   <= o_mem_en & ~o_mem_we;
         r_rd_port_b <= w_gnt_b;
         r_io_write  <= w_io_hit;
         r_io_data   <= w_io_hit ? o_mem_wdata : '0;
      end
   end

   assign o_a_rvalid = r_rd_pend & ~r_rd_port_b;
   assign o_b_rvalid = r_rd_pend &  r_rd_port_b;
   assign o_a_rdata  = o_a_rvalid ? i_mem_rdata : '0;
   assign o_b_rdata  = o_b_rvalid ? i_mem_rdata : '0;
   assign o_io_write = r_io_write;
   assign o_io_data  = r_io_data;

endmodule
